// File: rtl/mac2_arb_pkg.sv
// Shared types and helpers for the dual-lane multiply-add arbiter.
//  MAX_REQ     largest supported requester count (sizes the scan vector)
//  ID_W        width of a requester id / round-robin pointer
//  LANES       number of MAC lanes fed per clock
//  lane_tag_t  {vld, id}, the owner of a lane's operation
//  rr_pick2    round-robin selection of up to two requesters
package mac2_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;
  localparam int LANES   = 2;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } lane_tag_t;

  typedef lane_tag_t [LANES-1:0] lane_pair_t;

  // Scans ptr, ptr+1, ... modulo MAX_REQ. Callers zero the bits at or above
  // their requester count, so the visiting order matches a scan modulo the
  // real count as long as ptr stays below that count.
  // Element [0] is the first valid requester, element [1] the second.
  function automatic lane_pair_t rr_pick2(input logic [MAX_REQ-1:0] valid,
                                          input logic [ID_W-1:0]    ptr);
    lane_pair_t      pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (valid[idx]) begin
        if (!pick[0].vld) begin
          pick[0].vld = 1'b1;
          pick[0].id  = idx;
        end else if (!pick[1].vld) begin
          pick[1].vld = 1'b1;
          pick[1].id  = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ice40_2mac8x8.sv
// Dual-lane 8x8 multiply-add unit with registered inputs.
// Each lane computes y = s + a*b (sub = 0) or y = s - a*b (sub = 1), modulo 2^16.
// Operands are registered on the clock edge; y is combinational from those
// registers, so y is valid in the cycle after the operands are presented.
//  clock, reset           rising-edge clock, synchronous active-high reset
//  a0, b0, s0, sub0       lane 0 operands
//  a1, b1, s1, sub1       lane 1 operands
//  y0, y1                 lane results
//  SIGNED                 1 = a, b are two's complement, 0 = unsigned
module ice40_2mac8x8 #(
  parameter bit SIGNED = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [15:0] s0,
  input  logic        sub0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  input  logic [15:0] s1,
  input  logic        sub1,
  output logic [15:0] y0,
  output logic [15:0] y1
);

  logic [7:0]  a0_q, b0_q, a1_q, b1_q;
  logic [15:0] s0_q, s1_q;
  logic        sub0_q, sub1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      a0_q   <= '0;
      b0_q   <= '0;
      s0_q   <= '0;
      sub0_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      s1_q   <= '0;
      sub1_q <= 1'b0;
    end else begin
      a0_q   <= a0;
      b0_q   <= b0;
      s0_q   <= s0;
      sub0_q <= sub0;
      a1_q   <= a1;
      b1_q   <= b1;
      s1_q   <= s1;
      sub1_q <= sub1;
    end
  end

  // Extending both operands to 16 bits and keeping the low 16 bits of the
  // product gives the exact product modulo 2^16 in either interpretation.
  function automatic logic [15:0] ext8(input logic [7:0] v);
    return SIGNED ? {{8{v[7]}}, v} : {8'h00, v};
  endfunction

  function automatic logic [15:0] mac(input logic [7:0] a, input logic [7:0] b,
                                      input logic [15:0] s, input logic sub);
    logic [15:0] p;
    p = ext8(a) * ext8(b);
    return sub ? (s - p) : (s + p);
  endfunction

  assign y0 = mac(a0_q, b0_q, s0_q, sub0_q);
  assign y1 = mac(a1_q, b1_q, s1_q, sub1_q);

endmodule

// File: rtl/mac2_arbiter.sv
// Shares one dual-lane multiply-add unit among NREQ requesters.
// Up to two requests are granted per clock (one per lane) in round-robin
// order; each result returns to its owner exactly two cycles after the grant.
//  clock, reset   rising-edge clock, synchronous active-high reset
//  req_valid[i]   requester i presents an operation
//  req_ready[i]   requester i is granted this cycle (combinational)
//  req_a, req_b   8-bit operands, requester i at [8i+:8]
//  req_s          16-bit addend, requester i at [16i+:16]
//  req_sub[i]     1 = s - a*b, 0 = s + a*b
//  rsp_valid[i]   one-cycle pulse: result for requester i
//  rsp_y          result for requester i at [16i+:16], held between pulses
//
// Handshake: an operation transfers in any cycle where req_valid[i] and
// req_ready[i] are both high. A requester keeps valid and its operands stable
// until it sees ready, and may present a new operation in the next cycle.
// Responses have no backpressure; rsp_valid is a single-cycle pulse.
module mac2_arbiter
  import mac2_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*16-1:0] req_s,
  input  logic [NREQ-1:0]   req_sub,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*16-1:0] rsp_y
);

  logic [ID_W-1:0]    ptr;
  logic [MAX_REQ-1:0] valid_pad;
  lane_pair_t         pick;
  lane_tag_t          tag_q [LANES];

  logic [7:0]  lane_a   [LANES];
  logic [7:0]  lane_b   [LANES];
  logic [15:0] lane_s   [LANES];
  logic        lane_sub [LANES];
  logic [15:0] mac_y    [LANES];

  // Nothing is granted while reset is high.
  always_comb begin
    valid_pad = '0;
    if (!reset) valid_pad[NREQ-1:0] = req_valid;
  end

  assign pick = rr_pick2(valid_pad, ptr);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (pick[0].vld && (pick[0].id == ID_W'(i))) ||
                     (pick[1].vld && (pick[1].id == ID_W'(i)));
    end
  end

  // Idle lanes feed zeros so the MAC sees a quiet input.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l]   = '0;
      lane_b[l]   = '0;
      lane_s[l]   = '0;
      lane_sub[l] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (pick[l].vld && (pick[l].id == ID_W'(i))) begin
          lane_a[l]   = req_a[8*i +: 8];
          lane_b[l]   = req_b[8*i +: 8];
          lane_s[l]   = req_s[16*i +: 16];
          lane_sub[l] = req_sub[i];
        end
      end
    end
  end

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(NREQ-1)) ? '0 : id + 1'b1;
  endfunction

  // The pointer moves past the last requester served; lane 1 is only ever
  // granted together with lane 0, and it is the later one in scan order.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (pick[1].vld) begin
      ptr <= next_ptr(pick[1].id);
    end else if (pick[0].vld) begin
      ptr <= next_ptr(pick[0].id);
    end
  end

  // Tags travel alongside the MAC input registers so they line up with y.
  always_ff @(posedge clock) begin
    for (int l = 0; l < LANES; l++) begin
      if (reset) tag_q[l] <= '0;
      else       tag_q[l] <= pick[l];
    end
  end

  ice40_2mac8x8 #(
    .SIGNED (SIGNED)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .a0    (lane_a[0]),
    .b0    (lane_b[0]),
    .s0    (lane_s[0]),
    .sub0  (lane_sub[0]),
    .a1    (lane_a[1]),
    .b1    (lane_b[1]),
    .s1    (lane_s[1]),
    .sub1  (lane_sub[1]),
    .y0    (mac_y[0]),
    .y1    (mac_y[1])
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      rsp_valid <= '0;
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (tag_q[l].vld && (tag_q[l].id == ID_W'(i))) begin
            rsp_valid[i]       <= 1'b1;
            rsp_y[16*i +: 16]  <= mac_y[l];
          end
        end
      end
    end
  end

  // The arbiter never hands both lanes to one requester.
  lane_conflict_a: assert property (@(posedge clock) disable iff (reset)
    !(tag_q[0].vld && tag_q[1].vld && (tag_q[0].id == tag_q[1].id)));

endmodule
